// File: rtl/free_page_pool_pkg.sv
// Definitions shared by the page-manager blocks: pool geometry defaults and
// the pool controller state encoding.
package free_page_pool_pkg;

   localparam int DEF_PAGE_NUM = 2048;
   localparam int DEF_ADDR_W   = $clog2(DEF_PAGE_NUM);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } fpp_state_e;

endpackage

// File: rtl/fpp_push_compact.sv
// Decides which release ports are accepted this cycle and packs the accepted
// pages into consecutive slots starting at the tail, lowest port first.
module fpp_push_compact
   import free_page_pool_pkg::*;
#(
   parameter int PAGE_NUM = DEF_PAGE_NUM,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int PUSH_N   = 2,
   parameter int CNT_W    = $clog2(PUSH_N + 1)
) (
   input  logic                     run,
   input  logic                     pop_fire,
   input  logic [ADDR_W:0]          count,
   input  logic [PUSH_N-1:0]        push_en,
   output logic [PUSH_N-1:0]        accept,
   output logic [PUSH_N*ADDR_W-1:0] offset,
   output logic [CNT_W-1:0]         accept_cnt
);

   localparam logic [ADDR_W+1:0] CAP = (ADDR_W + 2)'(PAGE_NUM);

   logic [ADDR_W+1:0] occ;

   // A page popped this cycle frees its slot for any port; each accepted
   // port then consumes one slot before the next port is considered.
   always_comb begin
      occ        = {1'b0, count} - (ADDR_W + 2)'(pop_fire);
      accept     = '0;
      offset     = '0;
      accept_cnt = '0;
      for (int k = 0; k < PUSH_N; k++) begin
         offset[k*ADDR_W +: ADDR_W] = ADDR_W'(accept_cnt);
         if (run && push_en[k] && (occ < CAP)) begin
            accept[k]  = 1'b1;
            occ        = occ + (ADDR_W + 2)'(1);
            accept_cnt = accept_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/free_page_pool.sv
// Circular free-page list: filled with every page at init, pages are handed out
// first-word-fall-through at the head and released back at the tail.
module free_page_pool
   import free_page_pool_pkg::*;
#(
   parameter int PAGE_NUM = DEF_PAGE_NUM,
   parameter int ADDR_W   = $clog2(PAGE_NUM),
   parameter int PUSH_N   = 2,
   parameter int LOW_WM   = 16
) (
   input  logic                     sys_clk,
   input  logic                     rst_n,
   input  logic                     flush,
   output logic                     pop_valid,
   input  logic                     pop_ready,
   output logic [ADDR_W-1:0]        pop_addr,
   input  logic [PUSH_N-1:0]        push_en,
   input  logic [PUSH_N*ADDR_W-1:0] push_addr,
   output logic [ADDR_W:0]          count,
   output logic                     init_done,
   output logic                     almost_empty,
   output logic                     err_drop
);

   localparam int                CNT_W = $clog2(PUSH_N + 1);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(PAGE_NUM - 1);
   localparam logic [ADDR_W:0]   WM    = (ADDR_W + 1)'(LOW_WM);

   fpp_state_e               state_q, state_d;
   logic [ADDR_W-1:0]        head_q, head_d;
   logic [ADDR_W-1:0]        tail_q, tail_d;
   logic [ADDR_W-1:0]        init_cnt_q, init_cnt_d;
   logic [ADDR_W:0]          count_q, count_d;
   logic                     err_drop_q, err_drop_d;
   logic [ADDR_W-1:0]        mem [PAGE_NUM];
   logic                     run;
   logic                     pop_fire;
   logic [PUSH_N-1:0]        accept;
   logic [PUSH_N*ADDR_W-1:0] offset;
   logic [CNT_W-1:0]         accept_cnt;

   assign run          = (state_q == ST_RUN);
   assign pop_valid    = run && (count_q != '0);
   assign pop_fire     = pop_valid && pop_ready;
   assign pop_addr     = mem[head_q];
   assign count        = count_q;
   assign init_done    = run;
   assign almost_empty = run && (count_q <= WM);
   assign err_drop     = err_drop_q;

   fpp_push_compact #(
      .PAGE_NUM (PAGE_NUM),
      .ADDR_W   (ADDR_W),
      .PUSH_N   (PUSH_N),
      .CNT_W    (CNT_W)
   ) u_push_compact (
      .run        (run),
      .pop_fire   (pop_fire),
      .count      (count_q),
      .push_en    (push_en),
      .accept     (accept),
      .offset     (offset),
      .accept_cnt (accept_cnt)
   );

   // Flush wins over everything and quietly discards that cycle's traffic.
   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      init_cnt_d = init_cnt_q;
      count_d    = count_q;
      err_drop_d = err_drop_q;
      if (flush) begin
         state_d    = ST_INIT;
         head_d     = '0;
         tail_d     = '0;
         init_cnt_d = '0;
         count_d    = '0;
      end else if (!run) begin
         tail_d     = tail_q + ADDR_W'(1);
         init_cnt_d = init_cnt_q + ADDR_W'(1);
         count_d    = count_q + (ADDR_W + 1)'(1);
         err_drop_d = err_drop_q | (|push_en);
         if (init_cnt_q == LAST) begin
            state_d = ST_RUN;
         end
      end else begin
         head_d     = head_q + ADDR_W'(pop_fire);
         tail_d     = tail_q + ADDR_W'(accept_cnt);
         count_d    = count_q + (ADDR_W + 1)'(accept_cnt) - (ADDR_W + 1)'(pop_fire);
         err_drop_d = err_drop_q | (|(push_en & ~accept));
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         head_q     <= '0;
         tail_q     <= '0;
         init_cnt_q <= '0;
         count_q    <= '0;
         err_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         init_cnt_q <= init_cnt_d;
         count_q    <= count_d;
         err_drop_q <= err_drop_d;
      end
   end

   // Page storage is deliberately left out of reset; init rewrites every slot.
   always_ff @(posedge sys_clk) begin
      if (!flush) begin
         if (!run) begin
            mem[init_cnt_q] <= init_cnt_q;
         end else begin
            for (int k = 0; k < PUSH_N; k++) begin
               if (accept[k]) begin
                  mem[tail_q + offset[k*ADDR_W +: ADDR_W]] <= push_addr[k*ADDR_W +: ADDR_W];
               end
            end
         end
      end
   end

endmodule

// File: doc/free_page_pool.md
FREE_PAGE_POOL -- requirements
Module: free_page_pool

Interface
REQ-001 Parameter PAGE_NUM, default 2048: pages managed; SHALL be a power of two >= 4.
REQ-002 Parameter ADDR_W, default $clog2(PAGE_NUM) = 11: page address width.
REQ-003 Parameter PUSH_N, default 2: number of independent release (push) ports.
REQ-004 Parameter LOW_WM, default 16: almost-empty threshold in pages.
REQ-005 sys_clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 flush  in  1  one-cycle pulse; discards contents and re-initialises the pool.
REQ-008 pop_valid  out  1  free page available at pop_addr.
REQ-009 pop_ready  in  1  consumer takes pop_addr this cycle.
REQ-010 pop_addr  out  ADDR_W  head page address (first-word-fall-through).
REQ-011 push_en  in  PUSH_N  per-port release strobe.
REQ-012 push_addr  in  PUSH_N*ADDR_W  released page addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-013 count  out  ADDR_W+1  free pages currently held.
REQ-014 init_done  out  1  high in RUN state.
REQ-015 almost_empty  out  1  count <= LOW_WM, RUN state only.
REQ-016 err_drop  out  1  sticky; a push was discarded.

Function
REQ-017 FSM states: INIT, RUN. Reset or flush enters INIT with init_cnt=0, head=0, tail=0, count=0.
REQ-018 INIT: one entry per cycle, mem[init_cnt]=init_cnt, tail and count increment; after the write with init_cnt=PAGE_NUM-1, next state RUN; INIT lasts exactly PAGE_NUM cycles.
REQ-019 In INIT pop_valid=0 and every asserted push_en is discarded and sets err_drop.
REQ-020 RUN: pop_valid = (count != 0); pop_addr = mem[head] combinationally; pop fires when pop_valid && pop_ready; head increments.
REQ-021 pop_ready while pop_valid=0 has no effect and is not an error.
REQ-022 Pushes accepted in one cycle are written at tail, tail+1, ... in ascending port index; tail advances by the accepted count.
REQ-023 A push is accepted only if count - pop_fire + (pushes accepted on lower ports) < PAGE_NUM; otherwise discarded and err_drop set.
REQ-024 count_next = count + accepted_pushes - pop_fire, same cycle; a pop and push together keep count consistent at every level including 0 and PAGE_NUM.
REQ-025 A page pushed while count=0 SHALL NOT appear at pop_addr the same cycle; pop_valid rises the next cycle (latency 1 push-to-pop).
REQ-026 head and tail are ADDR_W bits and wrap modulo PAGE_NUM with no special-case logic.
REQ-027 No duplicate or range check on push_addr; uniqueness is the caller's responsibility.
REQ-028 flush has priority over any push/pop in the same cycle; those transactions are discarded without setting err_drop; err_drop is cleared only by rst_n.
REQ-029 pop_valid, count, init_done, almost_empty, err_drop are registered or derived only from registered state (no input-to-output combinational path except none).

Reset
REQ-030 On rst_n low: state=INIT, head=0, tail=0, init_cnt=0, count=0, pop_valid=0, init_done=0, almost_empty=0, err_drop=0; pop_addr undefined-don't-care; mem contents not reset.
REQ-031 Reset asserted mid-operation aborts all transactions immediately; release restarts the full INIT sequence.

Structure
REQ-032 Shared package holds the FSM state enum (INIT, RUN) and the default PAGE_NUM / ADDR_W constants used by other page-manager blocks.
REQ-033 Storage is a register array (multi-write per cycle); one sub-module, fpp_push_compact, computes per-port accept flags and write offsets from push_en and free space.

Verification
REQ-034 Reset release, idle -> init_done rises after exactly 2048 cycles; count=2048; pop_addr=0; pop_valid=1; almost_empty=0.
REQ-035 pop_ready held high 2048 cycles after init -> pop_addr sequence 0..2047, then pop_valid=0, count=0, almost_empty=1 from count=16 onward.
REQ-036 Empty pool, same cycle push_en=2'b11, port0=5, port1=9 -> next cycle pop_valid=1, pop_addr=5, count=2; after one pop pop_addr=9.
REQ-037 Full pool (count=2048), push_en=2'b11 with no pop -> both discarded, err_drop=1, count stays 2048; with pop same cycle -> port0 accepted, port1 dropped, count 2048.
REQ-038 RUN with count=1, pop and single push same cycle -> count stays 1, pushed page at pop_addr next cycle; flush in a later cycle -> init_done=0, 2048-cycle INIT repeats, pop_addr=0 afterward.
